// File: rtl/ldm_stm_seq_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer:
// FSM state encoding, register-file constants and the bitmap helper.
package ldm_stm_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REG = 3'd1,
        MEM    = 3'd2,
        WB     = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0]  NO_WRITE_SEL = 4'hF;
    localparam logic [31:0] WORD_BYTES   = 32'd4;

    // r15 is never transferred, so it is stripped from every bitmap at start.
    localparam logic [15:0] XFER_MASK    = 16'h7FFF;

    function automatic logic [15:0] clear_bit(input logic [15:0] vec, input logic [3:0] idx);
        return vec & ~(16'h0001 << idx);
    endfunction

endpackage

// File: rtl/ldm_stm_seq_prio_enc16.sv
// 16-bit priority encoder: index of the lowest set bit plus an any-bit-set flag.
module prio_enc16 (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        valid
);

    always_comb begin
        // NOTE: every output gets a value before the loop so no path leaves it unassigned (no latch).
        idx   = 4'h0;
        valid = |vec;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// Load/store-multiple sequencer: walks a register bitmap in ascending order,
// moving one word per register between the register file and memory.
module ldm_stm_seq
    import ldm_stm_seq_pkg::*;
(
    input  logic        clock,
    input  logic        not_reset,
    input  logic        start,
    input  logic        is_load,
    input  logic [15:0] reg_list,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic [31:0] final_addr,
    output logic [3:0]  rf_sel_p0,
    input  logic [31:0] rf_p0,
    output logic [3:0]  rf_sel_in,
    output logic [31:0] rf_in_reg,
    output logic        rf_not_enable,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    logic [15:0] pending;
    logic [31:0] addr;
    logic        load_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] final_q;

    logic [15:0] req_list;
    logic [15:0] enc_vec;
    logic [15:0] remaining;
    logic [3:0]  cur_idx;
    logic        cur_valid;
    logic [31:0] addr_next;

    assign req_list = reg_list & XFER_MASK;

    // In IDLE the encoder looks at the incoming list so an empty request is
    // recognised in the same cycle; afterwards it tracks the pending bitmap.
    assign enc_vec = (state == IDLE) ? req_list : pending;

    prio_enc16 u_prio (
        .vec   (enc_vec),
        .idx   (cur_idx),
        .valid (cur_valid)
    );

    assign remaining = clear_bit(pending, cur_idx);
    assign addr_next = addr + WORD_BYTES;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!not_reset) begin
            state   <= IDLE;
            pending <= '0;
            addr    <= '0;
            load_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            final_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr    <= base_addr;
                        load_q  <= is_load;
                        pending <= req_list;
                        if (!cur_valid) begin
                            final_q <= base_addr;
                            state   <= DONE;
                        end else if (is_load) begin
                            state <= MEM;
                        end else begin
                            state <= RD_REG;
                        end
                    end
                end

                RD_REG: begin
                    wdata_q <= rf_p0;
                    state   <= MEM;
                end

                MEM: begin
                    if (mem_ack) begin
                        if (load_q) begin
                            rdata_q <= mem_rdata;
                            state   <= WB;
                        end else begin
                            pending <= remaining;
                            addr    <= addr_next;
                            if (remaining != '0) begin
                                state <= RD_REG;
                            end else begin
                                final_q <= addr_next;
                                state   <= DONE;
                            end
                        end
                    end
                end

                WB: begin
                    pending <= remaining;
                    addr    <= addr_next;
                    if (remaining != '0) begin
                        state <= MEM;
                    end else begin
                        final_q <= addr_next;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy          = state inside {RD_REG, MEM, WB};
    assign done          = (state == DONE);
    assign final_addr    = final_q;

    assign mem_req       = (state == MEM);
    assign mem_we        = mem_req & ~load_q;
    assign mem_addr      = addr;
    assign mem_wdata     = wdata_q;

    assign rf_sel_p0     = (state == RD_REG) ? cur_idx : 4'h0;
    assign rf_sel_in     = (state == WB) ? cur_idx : NO_WRITE_SEL;
    assign rf_in_reg     = rdata_q;
    assign rf_not_enable = (state != WB);

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq with a register-file model, a memory
// responder with programmable wait states and a list-walking reference model.
module tb_ldm_stm_seq;

    logic        clock = 1'b0;
    logic        not_reset;
    logic        start;
    logic        is_load;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic [31:0] final_addr;
    logic [3:0]  rf_sel_p0;
    logic [31:0] rf_p0;
    logic [3:0]  rf_sel_in;
    logic [31:0] rf_in_reg;
    logic        rf_not_enable;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clock = ~clock;

    ldm_stm_seq dut (
        .clock         (clock),
        .not_reset     (not_reset),
        .start         (start),
        .is_load       (is_load),
        .reg_list      (reg_list),
        .base_addr     (base_addr),
        .busy          (busy),
        .done          (done),
        .final_addr    (final_addr),
        .rf_sel_p0     (rf_sel_p0),
        .rf_p0         (rf_p0),
        .rf_sel_in     (rf_sel_in),
        .rf_in_reg     (rf_in_reg),
        .rf_not_enable (rf_not_enable),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Register file and sparse memory models
    logic [31:0] rf [16];
    logic [31:0] mem_m [logic [31:0]];
    assign rf_p0 = rf[rf_sel_p0];

    // Responder state and transaction logs
    int          ack_wait   = 0;
    int          wait_cnt   = 0;
    int          req_cycles = 0;
    int          stab_err   = 0;
    bit          waiting    = 0;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    logic [31:0] bus_addr_q [$];
    logic [31:0] bus_data_q [$];
    logic        bus_we_q   [$];
    int          rfw_sel_q  [$];
    logic [31:0] rfw_data_q [$];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Drive ack/rdata for the coming edge and record what the DUT presents.
    always @(negedge clock) begin
        if (mem_req === 1'b1) begin
            req_cycles++;
            if (waiting && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
                stab_err++;
            if (wait_cnt >= ack_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_read(mem_addr);
                bus_addr_q.push_back(mem_addr);
                bus_we_q.push_back(mem_we);
                bus_data_q.push_back(mem_we ? mem_wdata : mem_rdata);
                if (mem_we) mem_m[mem_addr] = mem_wdata;
                wait_cnt = 0;
                waiting  = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                wait_cnt++;
                waiting = 1;
                p_addr  = mem_addr;
                p_we    = mem_we;
                p_wdata = mem_wdata;
            end
        end else begin
            // Spurious acks while idle must be ignored by the DUT.
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            wait_cnt  = 0;
            waiting   = 0;
        end
        if (rf_not_enable === 1'b0 && rf_sel_in !== 4'hF) begin
            rf[rf_sel_in] = rf_in_reg;
            rfw_sel_q.push_back(int'(rf_sel_in));
            rfw_data_q.push_back(rf_in_reg);
        end
    end

    task automatic clear_logs();
        bus_addr_q.delete();
        bus_data_q.delete();
        bus_we_q.delete();
        rfw_sel_q.delete();
        rfw_data_q.delete();
        req_cycles = 0;
        stab_err   = 0;
    endtask

    // Launch one transfer, scramble the inputs (including start) while busy,
    // and return in the DONE cycle with its latency and final address.
    task automatic run_xfer(input bit ld, input logic [15:0] list, input logic [31:0] base,
                            input int w, output int lat, output logic [31:0] fin);
        clear_logs();
        ack_wait  = w;
        is_load   = ld;
        reg_list  = list;
        base_addr = base;
        start     = 1'b1;
        @(posedge clock); #1;
        lat = 1;
        while (done !== 1'b1 && lat < 1000) begin
            start     = 1'($urandom_range(0, 1));
            is_load   = 1'($urandom_range(0, 1));
            reg_list  = 16'($urandom);
            base_addr = $urandom;
            @(posedge clock); #1;
            lat++;
        end
        start = 1'b0;
        fin   = final_addr;
    endtask

    task automatic test_reset();
        not_reset = 1'b0;
        start     = 1'b1;
        is_load   = 1'b1;
        reg_list  = 16'hFFFF;
        base_addr = 32'h1234_5678;
        repeat (2) @(posedge clock);
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
        n_total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_total++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_total++; if (final_addr !== 32'h0) $display("FAIL reset_final_addr: got %h want 0", final_addr); else n_pass++;
        n_total++; if (rf_sel_p0 !== 4'h0) $display("FAIL reset_rf_sel_p0: got %h want 0", rf_sel_p0); else n_pass++;
        n_total++; if (rf_sel_in !== 4'hF) $display("FAIL reset_rf_sel_in: got %h want f", rf_sel_in); else n_pass++;
        n_total++; if (rf_in_reg !== 32'h0) $display("FAIL reset_rf_in_reg: got %h want 0", rf_in_reg); else n_pass++;
        n_total++; if (rf_not_enable !== 1'b1) $display("FAIL reset_rf_not_enable: got %b want 1", rf_not_enable); else n_pass++;
        start     = 1'b0;
        not_reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_stm();
        int lat;
        logic [31:0] fin;
        rf[5] = 32'h1234_5678;
        rf[6] = 32'h8765_4321;
        run_xfer(1'b0, 16'h0060, 32'h0000_1000, 0, lat, fin);
        n_total++; if (lat !== 5) $display("FAIL stm_latency: got %0d want 5", lat); else n_pass++;
        n_total++; if (fin !== 32'h1008) $display("FAIL stm_final_addr: got %h want 1008", fin); else n_pass++;
        n_total++; if (bus_addr_q.size() !== 2) $display("FAIL stm_count: got %0d want 2", bus_addr_q.size()); else n_pass++;
        if (bus_addr_q.size() == 2) begin
            n_total++; if (bus_addr_q[0] !== 32'h1000 || bus_data_q[0] !== 32'h1234_5678 || bus_we_q[0] !== 1'b1)
                $display("FAIL stm_word0: got %h/%h/%b want 1000/12345678/1", bus_addr_q[0], bus_data_q[0], bus_we_q[0]); else n_pass++;
            n_total++; if (bus_addr_q[1] !== 32'h1004 || bus_data_q[1] !== 32'h8765_4321 || bus_we_q[1] !== 1'b1)
                $display("FAIL stm_word1: got %h/%h/%b want 1004/87654321/1", bus_addr_q[1], bus_data_q[1], bus_we_q[1]); else n_pass++;
        end
        n_total++; if (rfw_sel_q.size() !== 0) $display("FAIL stm_rf_writes: got %0d want 0", rfw_sel_q.size()); else n_pass++;
        @(posedge clock); #1;
        n_total++; if (done !== 1'b0 || busy !== 1'b0 || final_addr !== 32'h1008)
            $display("FAIL stm_after_done: got done=%b busy=%b final=%h want 0/0/1008", done, busy, final_addr); else n_pass++;
    endtask

    task automatic test_ldm();
        int lat;
        logic [31:0] fin;
        mem_m[32'h2000] = 32'h0000_DEAD;
        mem_m[32'h2004] = 32'h0000_BEEF;
        run_xfer(1'b1, 16'h0021, 32'h0000_2000, 2, lat, fin);
        n_total++; if (stab_err !== 0) $display("FAIL ldm_stable: got %0d changes want 0", stab_err); else n_pass++;
        n_total++; if (req_cycles !== 6) $display("FAIL ldm_req_cycles: got %0d want 6", req_cycles); else n_pass++;
        n_total++; if (lat !== 9) $display("FAIL ldm_latency: got %0d want 9", lat); else n_pass++;
        n_total++; if (rf[0] !== 32'h0000_DEAD) $display("FAIL ldm_r0: got %h want dead", rf[0]); else n_pass++;
        n_total++; if (rf[5] !== 32'h0000_BEEF) $display("FAIL ldm_r5: got %h want beef", rf[5]); else n_pass++;
        n_total++; if (fin !== 32'h2008) $display("FAIL ldm_final_addr: got %h want 2008", fin); else n_pass++;
        n_total++; if (rfw_sel_q.size() !== 2) $display("FAIL ldm_rf_writes: got %0d want 2", rfw_sel_q.size()); else n_pass++;
        if (bus_addr_q.size() == 2) begin
            n_total++; if (bus_addr_q[0] !== 32'h2000 || bus_we_q[0] !== 1'b0 || bus_addr_q[1] !== 32'h2004 || bus_we_q[1] !== 1'b0)
                $display("FAIL ldm_bus: got %h/%b %h/%b want 2000/0 2004/0", bus_addr_q[0], bus_we_q[0], bus_addr_q[1], bus_we_q[1]); else n_pass++;
        end
        @(posedge clock); #1;
    endtask

    task automatic test_empty();
        int lat;
        logic [31:0] fin;
        logic [15:0] lists [2];
        lists[0] = 16'h0000;
        lists[1] = 16'h8000;
        for (int t = 0; t < 2; t++) begin
            run_xfer(1'(t), lists[t], 32'h0000_4440 + 32'(t * 16), 0, lat, fin);
            n_total++; if (lat !== 1) $display("FAIL empty%0d_latency: got %0d want 1", t, lat); else n_pass++;
            n_total++; if (req_cycles !== 0) $display("FAIL empty%0d_mem_req: got %0d cycles want 0", t, req_cycles); else n_pass++;
            n_total++; if (fin !== 32'h0000_4440 + 32'(t * 16))
                $display("FAIL empty%0d_final_addr: got %h want %h", t, fin, 32'h0000_4440 + 32'(t * 16)); else n_pass++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_r15();
        int lat;
        logic [31:0] fin;
        logic [31:0] r15_old;
        r15_old = rf[15];
        run_xfer(1'b1, 16'h8001, 32'h0000_5000, 1, lat, fin);
        n_total++; if (rfw_sel_q.size() !== 1) $display("FAIL r15_writes: got %0d want 1", rfw_sel_q.size()); else n_pass++;
        n_total++; if (rf[0] !== mem_read(32'h5000)) $display("FAIL r15_r0: got %h want %h", rf[0], mem_read(32'h5000)); else n_pass++;
        n_total++; if (rf[15] !== r15_old) $display("FAIL r15_untouched: got %h want %h", rf[15], r15_old); else n_pass++;
        n_total++; if (fin !== 32'h5004) $display("FAIL r15_final_addr: got %h want 5004", fin); else n_pass++;
        @(posedge clock); #1;
    endtask

    task automatic test_wrap();
        int lat;
        logic [31:0] fin;
        rf[1] = 32'hA1A1_A1A1;
        rf[2] = 32'hB2B2_B2B2;
        rf[9] = 32'hC9C9_C9C9;
        run_xfer(1'b0, 16'h0206, 32'hFFFF_FFF8, 0, lat, fin);
        n_total++; if (fin !== 32'h0000_0004) $display("FAIL wrap_final_addr: got %h want 00000004", fin); else n_pass++;
        n_total++; if (bus_addr_q.size() !== 3) $display("FAIL wrap_count: got %0d want 3", bus_addr_q.size()); else n_pass++;
        if (bus_addr_q.size() == 3) begin
            n_total++; if (bus_addr_q[2] !== 32'h0 || bus_data_q[2] !== 32'hC9C9_C9C9)
                $display("FAIL wrap_word2: got %h/%h want 00000000/c9c9c9c9", bus_addr_q[2], bus_data_q[2]); else n_pass++;
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_abort();
        logic [31:0] r1_old;
        clear_logs();
        rf[1]     = 32'hCAFE_F00D;
        r1_old    = rf[1];
        ack_wait  = 0;
        is_load   = 1'b1;
        reg_list  = 16'h0003;
        base_addr = 32'h0000_3000;
        start     = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        n_total++; if (rf_not_enable !== 1'b0) $display("FAIL abort_wb_r0: got rf_not_enable=%b want 0", rf_not_enable); else n_pass++;
        @(posedge clock); #1;
        not_reset = 1'b0;
        @(posedge clock); #1;
        n_total++; if (busy !== 1'b0 || mem_req !== 1'b0 || rf_not_enable !== 1'b1 || rf_sel_in !== 4'hF)
            $display("FAIL abort_outputs: got busy=%b req=%b ne=%b sel=%h want 0/0/1/f", busy, mem_req, rf_not_enable, rf_sel_in); else n_pass++;
        not_reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_total++; if (rf[0] !== mem_read(32'h3000)) $display("FAIL abort_r0: got %h want %h", rf[0], mem_read(32'h3000)); else n_pass++;
        n_total++; if (rf[1] !== r1_old) $display("FAIL abort_r1: got %h want %h", rf[1], r1_old); else n_pass++;
        n_total++; if (rfw_sel_q.size() !== 1) $display("FAIL abort_writes: got %0d want 1", rfw_sel_q.size()); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_idle: got busy=%b want 0", busy); else n_pass++;
    endtask

    // Reference: registers in ascending order, k-th selected one at base+4k.
    task automatic test_random();
        int          lat, w, k, exp_lat;
        logic [31:0] fin, base, a, exp_d;
        logic [15:0] list;
        bit          ld;
        logic [31:0] rf_before [16];
        for (int i = 0; i < 40; i++) begin
            ld   = 1'($urandom_range(0, 1));
            list = 16'($urandom);
            if (i % 7 == 0) list = list & 16'h8101;
            base = $urandom;
            base[1:0] = 2'b00;
            if (i % 5 == 0) base = 32'hFFFF_FFF0;
            w = $urandom_range(0, 3);
            for (int n = 0; n < 16; n++) rf[n] = $urandom;
            rf_before = rf;
            run_xfer(ld, list, base, w, lat, fin);
            k = 0;
            for (int n = 0; n < 15; n++) begin
                if (list[n]) begin
                    a = base + 32'(4 * k);
                    if (k < bus_addr_q.size()) begin
                        exp_d = ld ? mem_read(a) : rf_before[n];
                        n_total++; if (bus_addr_q[k] !== a || bus_we_q[k] !== !ld || bus_data_q[k] !== exp_d)
                            $display("FAIL rnd%0d_bus%0d: got %h/%b/%h want %h/%b/%h", i, k,
                                     bus_addr_q[k], bus_we_q[k], bus_data_q[k], a, !ld, exp_d); else n_pass++;
                    end
                    if (ld && k < rfw_sel_q.size()) begin
                        n_total++; if (rfw_sel_q[k] !== n || rfw_data_q[k] !== mem_read(a))
                            $display("FAIL rnd%0d_rf%0d: got r%0d=%h want r%0d=%h", i, k,
                                     rfw_sel_q[k], rfw_data_q[k], n, mem_read(a)); else n_pass++;
                    end
                    k++;
                end
            end
            exp_lat = 1 + k * (2 + w);
            n_total++; if (bus_addr_q.size() !== k) $display("FAIL rnd%0d_count: got %0d want %0d", i, bus_addr_q.size(), k); else n_pass++;
            n_total++; if (rfw_sel_q.size() !== (ld ? k : 0))
                $display("FAIL rnd%0d_rf_count: got %0d want %0d", i, rfw_sel_q.size(), ld ? k : 0); else n_pass++;
            n_total++; if (lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat); else n_pass++;
            n_total++; if (fin !== base + 32'(4 * k)) $display("FAIL rnd%0d_final_addr: got %h want %h", i, fin, base + 32'(4 * k)); else n_pass++;
            n_total++; if (stab_err !== 0) $display("FAIL rnd%0d_stable: got %0d changes want 0", i, stab_err); else n_pass++;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        for (int n = 0; n < 16; n++) rf[n] = 32'h0000_0100 + 32'(n);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        test_reset();
        test_stm();
        test_ldm();
        test_empty();
        test_r15();
        test_wrap();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ldm_stm_seq.md
LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-low; ports named clock and not_reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 not_reset  in  1  synchronous active-low reset.
REQ-004 start  in  1  begin a block transfer; sampled only in IDLE.
REQ-005 is_load  in  1  1 = LDM (memory to registers), 0 = STM (registers to memory); sampled with start.
REQ-006 reg_list  in  16  register bitmap; bit n selects rn; sampled with start.
REQ-007 base_addr  in  32  first word address; sampled with start.
REQ-008 busy  out  1  transfer in progress.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 final_addr  out  32  base + 4*transferred count; valid while done=1, then held.
REQ-011 rf_sel_p0  out  4  register-file read-port-0 select.
REQ-012 rf_p0  in  32  register-file read data; combinational from rf_sel_p0.
REQ-013 rf_sel_in  out  4  register-file write select; 4'hF = no write.
REQ-014 rf_in_reg  out  32  register-file write data.
REQ-015 rf_not_enable  out  1  register-file write disable; active high.
REQ-016 mem_req  out  1  memory request valid.
REQ-017 mem_we  out  1  1 = write (STM), 0 = read (LDM); meaningful while mem_req=1.
REQ-018 mem_addr  out  32  word address; mem_wdata  out  32  store data.
REQ-019 mem_ack  in  1  request accepted; mem_rdata  in  32  read data, valid in the same cycle as mem_ack.

Function
REQ-020 States SHALL be IDLE, RD_REG, MEM, WB, DONE.
REQ-021 IDLE with start=1: latch operands and pending = reg_list & 16'h7FFF; go to DONE if pending==0, else RD_REG (STM) or MEM (LDM).
REQ-022 Transfer order SHALL be ascending register number, lowest set pending bit first; addresses increment-after: base, base+4, and so on.
REQ-023 RD_REG: rf_sel_p0 = current register; capture rf_p0 into mem_wdata at the edge; then MEM.
REQ-024 MEM: mem_req=1; mem_addr, mem_we and mem_wdata SHALL be held stable until the cycle mem_ack=1.
REQ-025 mem_ack is ignored while mem_req=0.
REQ-026 On ack, STM: clear the pending bit, advance the address; go to RD_REG if any pending bits remain, else DONE.
REQ-027 On ack, LDM: capture mem_rdata, then WB.
REQ-028 WB: rf_sel_in = current register, rf_in_reg = captured data, rf_not_enable=0 for exactly one cycle; clear the pending bit, advance the address; go to MEM or DONE.
REQ-029 Outside WB, rf_sel_in SHALL be 4'hF and rf_not_enable SHALL be 1.
REQ-030 DONE: done=1 and busy=0 for one cycle; final_addr valid; then IDLE.
REQ-031 busy SHALL be 1 in RD_REG, MEM and WB.
REQ-032 reg_list bit 15 (r15) SHALL be ignored: no transfer, not counted.
REQ-033 start SHALL be ignored outside IDLE.
REQ-034 Address arithmetic SHALL be 32-bit modulo and wrap silently past 32'hFFFFFFFC.
REQ-035 Minimum throughput SHALL be 2 cycles per register with zero-wait ack.

Reset
REQ-036 not_reset=0 at an edge SHALL force IDLE from any state, aborting any transfer in progress.
REQ-037 Register writes already completed before reset SHALL persist; no further writes SHALL occur.
REQ-038 Reset values SHALL be: busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, final_addr=0, rf_sel_p0=0, rf_sel_in=4'hF, rf_in_reg=0, rf_not_enable=1.

Structure
REQ-039 A shared package SHALL hold the state enum, NO_WRITE_SEL=4'hF and WORD_BYTES=4.
REQ-040 The block SHALL contain one sub-module, prio_enc16: lowest-set-bit index (4 bits) plus a valid flag.

Verification
REQ-041 Reset: not_reset=0 for 2 cycles with start=1 -> busy=0, mem_req=0, rf_sel_in=4'hF, rf_not_enable=1.
REQ-042 STM: r5=32'h12345678, r6=32'h87654321, list 16'h0060, base 32'h1000, ack immediate -> writes 32'h12345678 at 32'h1000 then 32'h87654321 at 32'h1004; done 5 cycles after start is sampled; final_addr=32'h1008.
REQ-043 LDM: list 16'h0021, base 32'h2000, ack in the 3rd MEM cycle, rdata 32'hDEAD then 32'hBEEF -> address and mem_we stable while waiting; r0=32'hDEAD, r5=32'hBEEF; final_addr=32'h2008.
REQ-044 Empty list or list 16'h8000 -> done the cycle after start, no mem_req, final_addr=base.
REQ-045 LDM list 16'h8001 -> only r0 loaded; final_addr=base+4.
REQ-046 Reset asserted in the cycle after r0's WB of an LDM with list 16'h0003 -> r0 updated, r1 unchanged, busy=0, mem_req=0.
